// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART tx arbitration path (also used by rx-side schedulers).
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT} uart_arb_state_t;

   localparam int unsigned UART_N_REQ       = 4;
   localparam int unsigned UART_FRAME_WD    = 8;
   localparam int unsigned UART_TIMEOUT_CYC = 65536;
   localparam int unsigned UART_MAX_BURST   = 4;

   // Round-robin successor of idx among n slots.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 32'd0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshake plus transmitter start/done link for uart_tx_arbiter.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ    = UART_N_REQ,
   parameter int unsigned FRAME_WD = UART_FRAME_WD
);
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ*FRAME_WD-1:0] req_data;
   logic [N_REQ-1:0]          req_ready;
   logic                      tx_start;
   logic [FRAME_WD-1:0]       tx_frame;
   logic                      tx_done;

   modport master (
      output req_valid, req_data, tx_done,
      input  req_ready, tx_start, tx_frame
   );

   modport slave (
      input  req_valid, req_data, tx_done,
      output req_ready, tx_start, tx_frame
   );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ = UART_N_REQ
) (
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic                     any,
   output logic [$clog2(N_REQ)-1:0] g
);
   localparam int unsigned PTR_WD = $clog2(N_REQ);

   int unsigned idx;
   logic        found;

   always_comb begin
      any   = |req_valid;
      g     = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_valid[idx[PTR_WD-1:0]]) begin
            g     = idx[PTR_WD-1:0];
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Optional multi-byte grants: define UART_ARB_BURST_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ       = UART_N_REQ,
   parameter int unsigned FRAME_WD    = UART_FRAME_WD,
   parameter int unsigned TIMEOUT_CYC = UART_TIMEOUT_CYC,
   parameter int unsigned MAX_BURST   = UART_MAX_BURST
) (
   input  logic                     clk,
   input  logic                     rst_n,
   uart_tx_arbiter_if.slave         bus,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     tx_timeout
);
   localparam int unsigned PTR_WD = $clog2(N_REQ);
   localparam int unsigned TMR_WD = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_START = START;
   localparam logic [1:0] ST_WAIT  = WAIT;

   logic [1:0]          state;
   logic [PTR_WD-1:0]   ptr;
   logic [PTR_WD-1:0]   pick_g;
   logic                pick_any;
   logic [TMR_WD-1:0]   timer;
   logic                timer_end;
   logic                tx_start_q;
   logic [FRAME_WD-1:0] frame_q;
   logic [FRAME_WD-1:0] pick_data;
   logic [N_REQ-1:0]    ready;
   logic [PTR_WD-1:0]   ptr_after_pick;
   logic [PTR_WD-1:0]   ptr_after_grant;

   uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_valid (bus.req_valid),
      .ptr       (ptr),
      .any       (pick_any),
      .g         (pick_g)
   );

   assign pick_data       = bus.req_data[int'(pick_g)*FRAME_WD +: FRAME_WD];
   assign ptr_after_pick  = PTR_WD'(rr_next(32'(pick_g), N_REQ));
   assign ptr_after_grant = PTR_WD'(rr_next(32'(grant_id), N_REQ));
   assign timer_end       = (timer == TMR_WD'(TIMEOUT_CYC - 1));
   assign busy            = (state != ST_IDLE);

   assign bus.tx_start  = tx_start_q;
   assign bus.tx_frame  = frame_q;
   assign bus.req_ready = ready;

`ifdef UART_ARB_BURST_EN
   localparam int unsigned BST_WD = $clog2(MAX_BURST + 1);

   logic [BST_WD-1:0]   burst_cnt;
   logic                burst_go;
   logic [FRAME_WD-1:0] own_data;

   assign own_data = bus.req_data[int'(grant_id)*FRAME_WD +: FRAME_WD];
   assign burst_go = (state == ST_WAIT) && bus.tx_done && bus.req_valid[grant_id]
                     && (burst_cnt < BST_WD'(MAX_BURST - 1));

   always_comb begin
      ready = '0;
      if (state == ST_IDLE && pick_any) ready[pick_g] = 1'b1;
      else if (burst_go)                ready[grant_id] = 1'b1;
   end
`else
   always_comb begin
      ready = '0;
      if (state == ST_IDLE && pick_any) ready[pick_g] = 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         grant_id   <= '0;
         frame_q    <= '0;
         tx_start_q <= 1'b0;
         tx_timeout <= 1'b0;
         timer      <= '0;
`ifdef UART_ARB_BURST_EN
         burst_cnt  <= '0;
`endif
      end else begin
         tx_start_q <= 1'b0;
         tx_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  frame_q    <= pick_data;
                  grant_id   <= pick_g;
                  tx_start_q <= 1'b1;
                  state      <= ST_START;
`ifndef UART_ARB_BURST_EN
                  ptr        <= ptr_after_pick;
`endif
               end
            end
            ST_START: begin
               timer <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // tx_done is tested first so it beats a coincident watchdog expiry
               if (bus.tx_done) begin
`ifdef UART_ARB_BURST_EN
                  if (burst_go) begin
                     frame_q    <= own_data;
                     burst_cnt  <= burst_cnt + 1'b1;
                     tx_start_q <= 1'b1;
                     state      <= ST_START;
                  end else begin
                     burst_cnt <= '0;
                     ptr       <= ptr_after_grant;
                     state     <= ST_IDLE;
                  end
`else
                  state <= ST_IDLE;
`endif
               end else if (timer_end) begin
                  tx_timeout <= 1'b1;
                  state      <= ST_IDLE;
`ifdef UART_ARB_BURST_EN
                  burst_cnt  <= '0;
                  ptr        <= ptr_after_grant;
`endif
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The pick-time pointer is unused when grants may span several bytes.
   logic unused_ptr;
   assign unused_ptr = ^ptr_after_pick;
endmodule
